// File: rtl/sparse_chunk_sram_rx.sv
// Receive side of the sparse-chunk SRAM write bus: stores {sparsemap, nonzero data} beats per chunk,
// tracks chunk completion, beat count and nonzero total, and serves 1-cycle registered reads.
module sparse_chunk_sram_rx #(
    parameter  int BUS_SIZE       = 32,
    parameter  int DAT_SIZE       = 8,
    parameter  int WR_DAT_CYC_NUM = 9,
    parameter  int CHUNK_NUM      = 16,
    localparam int DCW            = $clog2(WR_DAT_CYC_NUM),
    localparam int CKW            = $clog2(CHUNK_NUM),
    localparam int NZW            = $clog2(WR_DAT_CYC_NUM * BUS_SIZE + 1),
    localparam int PCW            = $clog2(BUS_SIZE + 1),
    localparam int DW             = BUS_SIZE * DAT_SIZE
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [BUS_SIZE-1:0]          wr_sparsemap_i,
    input  logic [DW-1:0]                wr_nonzero_data_i,
    input  logic                         wr_valid_i,
    input  logic [DCW-1:0]               wr_dat_count_i,
    input  logic [CKW-1:0]               wr_chunk_count_i,
    input  logic [CHUNK_NUM-1:0]         chunk_clr_i,
    input  logic                         rd_en_i,
    input  logic [CKW-1:0]               rd_chunk_i,
    input  logic [DCW-1:0]               rd_dat_count_i,
    output logic [BUS_SIZE-1:0]          rd_sparsemap_o,
    output logic [DW-1:0]                rd_nonzero_data_o,
    output logic [PCW-1:0]               rd_nz_cnt_o,
    output logic                         rd_valid_o,
    output logic                         rd_last_o,
    output logic [CHUNK_NUM-1:0]         chunk_ready_o,
    output logic [CHUNK_NUM*(DCW+1)-1:0] chunk_words_o,
    output logic [CHUNK_NUM*NZW-1:0]     chunk_nz_total_o,
    output logic                         err_o
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [DCW-1:0] LAST_DC = DCW'(WR_DAT_CYC_NUM - 1);
    localparam logic [DCW:0]   N_BEATS = (DCW+1)'(WR_DAT_CYC_NUM);

    function automatic logic [PCW-1:0] popcount(input logic [BUS_SIZE-1:0] v);
        logic [PCW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BUS_SIZE; i++) cnt += PCW'(v[i]);
        return cnt;
    endfunction

    logic [BUS_SIZE-1:0] map_mem [CHUNK_NUM][WR_DAT_CYC_NUM];
    logic [DW-1:0]       dat_mem [CHUNK_NUM][WR_DAT_CYC_NUM];

    state_t                         state;
    logic [CKW-1:0]                 cur_chunk;
    logic [DCW-1:0]                 last_dc;
    logic [NZW-1:0]                 acc_nz;
    logic [CHUNK_NUM-1:0][DCW:0]    words_q;
    logic [CHUNK_NUM-1:0][NZW-1:0]  nz_q;

    logic           dc_in_range, wr_ok, seq_ok, open_en, is_last;
    logic           close_a_en, close_b_en;
    logic [DCW:0]   close_a_words;
    logic [NZW-1:0] close_a_nz, beat_nz;
    logic [DCW:0]   rd_words;
    logic           rd_hit, rd_is_last;

    assign chunk_words_o    = words_q;
    assign chunk_nz_total_o = nz_q;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        dc_in_range   = 1'b0;
        wr_ok         = 1'b0;
        seq_ok        = 1'b0;
        open_en       = 1'b0;
        is_last       = 1'b0;
        close_a_en    = 1'b0;
        close_b_en    = 1'b0;
        close_a_words = '0;
        close_a_nz    = '0;
        beat_nz       = '0;
        rd_words      = '0;
        rd_hit        = 1'b0;
        rd_is_last    = 1'b0;

        dc_in_range = {1'b0, wr_dat_count_i} < N_BEATS;
        wr_ok       = wr_valid_i && dc_in_range;
        is_last     = wr_dat_count_i == LAST_DC;
        beat_nz     = NZW'(popcount(wr_sparsemap_i));
        seq_ok      = wr_ok && state == FILL && wr_chunk_count_i == cur_chunk
                      && wr_dat_count_i == last_dc + 1'b1;
        open_en     = wr_ok && !seq_ok;

        // Close the running chunk on a gap, on a protocol break, or when its final beat lands.
        close_a_en    = state == FILL && (!wr_valid_i || (wr_ok && (!seq_ok || is_last)));
        close_a_words = seq_ok ? {1'b0, wr_dat_count_i} + 1'b1 : {1'b0, last_dc} + 1'b1;
        close_a_nz    = seq_ok ? acc_nz + beat_nz : acc_nz;
        close_b_en    = open_en && is_last;

        rd_words   = words_q[rd_chunk_i];
        rd_hit     = rd_en_i && chunk_ready_o[rd_chunk_i] && ({1'b0, rd_dat_count_i} < rd_words);
        rd_is_last = ({1'b0, rd_dat_count_i} + 1'b1) == rd_words;
    end

    // NOTE: storage is never reset; only the bookkeeping that says which beats are valid is.
    always_ff @(posedge clk_i) begin
        if (rst_i && wr_ok) begin
            map_mem[wr_chunk_count_i][wr_dat_count_i] <= wr_sparsemap_i;
            dat_mem[wr_chunk_count_i][wr_dat_count_i] <= wr_nonzero_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state             <= IDLE;
            cur_chunk         <= '0;
            last_dc           <= '0;
            acc_nz            <= '0;
            err_o             <= 1'b0;
            chunk_ready_o     <= '0;
            words_q           <= '0;
            nz_q              <= '0;
            rd_valid_o        <= 1'b0;
            rd_last_o         <= 1'b0;
            rd_sparsemap_o    <= '0;
            rd_nonzero_data_o <= '0;
            rd_nz_cnt_o       <= '0;
        end else begin
            if (wr_valid_i && !dc_in_range) begin
                err_o <= 1'b1;
            end else if (wr_valid_i) begin
                last_dc <= wr_dat_count_i;
                if (open_en) begin
                    cur_chunk <= wr_chunk_count_i;
                    acc_nz    <= beat_nz;
                    if (wr_dat_count_i != '0) err_o <= 1'b1;
                end else begin
                    acc_nz <= acc_nz + beat_nz;
                end
                state <= is_last ? IDLE : FILL;
            end else begin
                state <= IDLE;
            end

            // Order matters: release, close of running chunk, reopen clears, close of a single-beat chunk.
            for (int c = 0; c < CHUNK_NUM; c++) begin
                if (chunk_clr_i[c]) begin
                    chunk_ready_o[c] <= 1'b0;
                    words_q[c]       <= '0;
                    nz_q[c]          <= '0;
                end
                if (close_a_en && cur_chunk == CKW'(c)) begin
                    chunk_ready_o[c] <= 1'b1;
                    words_q[c]       <= close_a_words;
                    nz_q[c]          <= close_a_nz;
                end
                if (open_en && wr_chunk_count_i == CKW'(c)) chunk_ready_o[c] <= 1'b0;
                if (close_b_en && wr_chunk_count_i == CKW'(c)) begin
                    chunk_ready_o[c] <= 1'b1;
                    words_q[c]       <= N_BEATS;
                    nz_q[c]          <= beat_nz;
                end
            end

            rd_valid_o        <= rd_hit;
            rd_last_o         <= rd_hit && rd_is_last;
            rd_sparsemap_o    <= rd_hit ? map_mem[rd_chunk_i][rd_dat_count_i] : '0;
            rd_nonzero_data_o <= rd_hit ? dat_mem[rd_chunk_i][rd_dat_count_i] : '0;
            rd_nz_cnt_o       <= rd_hit ? popcount(map_mem[rd_chunk_i][rd_dat_count_i]) : '0;
        end
    end

endmodule

// File: tb/tb_sparse_chunk_sram_rx.sv
// Bench for sparse_chunk_sram_rx: chunk-level behavioural model checked every cycle plus directed literal checks.
module tb_sparse_chunk_sram_rx;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   wr_sparsemap_i;
    logic [255:0]  wr_nonzero_data_i;
    logic          wr_valid_i;
    logic [3:0]    wr_dat_count_i;
    logic [3:0]    wr_chunk_count_i;
    logic [15:0]   chunk_clr_i;
    logic          rd_en_i;
    logic [3:0]    rd_chunk_i;
    logic [3:0]    rd_dat_count_i;
    logic [31:0]   rd_sparsemap_o;
    logic [255:0]  rd_nonzero_data_o;
    logic [5:0]    rd_nz_cnt_o;
    logic          rd_valid_o;
    logic          rd_last_o;
    logic [15:0]   chunk_ready_o;
    logic [79:0]   chunk_words_o;
    logic [143:0]  chunk_nz_total_o;
    logic          err_o;

    sparse_chunk_sram_rx dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_sparsemap_i(wr_sparsemap_i), .wr_nonzero_data_i(wr_nonzero_data_i),
        .wr_valid_i(wr_valid_i), .wr_dat_count_i(wr_dat_count_i), .wr_chunk_count_i(wr_chunk_count_i),
        .chunk_clr_i(chunk_clr_i), .rd_en_i(rd_en_i), .rd_chunk_i(rd_chunk_i), .rd_dat_count_i(rd_dat_count_i),
        .rd_sparsemap_o(rd_sparsemap_o), .rd_nonzero_data_o(rd_nonzero_data_o), .rd_nz_cnt_o(rd_nz_cnt_o),
        .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o), .chunk_ready_o(chunk_ready_o),
        .chunk_words_o(chunk_words_o), .chunk_nz_total_o(chunk_nz_total_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_data(input int ch, input int dc, input int gen);
        logic [255:0] d;
        for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(ch * 16 + dc) ^ 8'(gen * 90) ^ 8'(i);
        return d;
    endfunction

    // Model: chunk-level view (which chunk is open, how many beats it holds, its running nonzero sum).
    logic [31:0]  m_map [16][9];
    logic [255:0] m_dat [16][9];
    logic [15:0]  m_ready;
    int           m_words [16];
    int           m_nz [16];
    bit           m_err, m_open;
    int           m_oc, m_beats, m_onz;
    bit           e_rv, e_last;
    logic [31:0]  e_map;
    logic [255:0] e_dat;

    task automatic m_close(input int c, input int w, input int n);
        m_ready[c] = 1'b1;
        m_words[c] = w;
        m_nz[c]    = n;
    endtask

    initial begin
        for (int c = 0; c < 16; c++)
            for (int d = 0; d < 9; d++) begin
                m_map[c][d] = '0;
                m_dat[c][d] = '0;
            end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            m_ready = '0;
            for (int c = 0; c < 16; c++) begin
                m_words[c] = 0;
                m_nz[c] = 0;
            end
            m_err = 0; m_open = 0; m_oc = 0; m_beats = 0; m_onz = 0;
            e_rv = 0; e_last = 0; e_map = '0; e_dat = '0;
        end else begin
            e_rv = rd_en_i && m_ready[rd_chunk_i] && int'(rd_dat_count_i) < m_words[rd_chunk_i];
            e_map  = e_rv ? m_map[rd_chunk_i][rd_dat_count_i] : '0;
            e_dat  = e_rv ? m_dat[rd_chunk_i][rd_dat_count_i] : '0;
            e_last = e_rv && int'(rd_dat_count_i) == m_words[rd_chunk_i] - 1;

            for (int c = 0; c < 16; c++)
                if (chunk_clr_i[c]) begin
                    m_ready[c] = 1'b0;
                    m_words[c] = 0;
                    m_nz[c] = 0;
                end

            if (wr_valid_i) begin
                if (int'(wr_dat_count_i) >= 9) begin
                    m_err = 1;
                end else begin
                    int ch, dc, p;
                    ch = int'(wr_chunk_count_i);
                    dc = int'(wr_dat_count_i);
                    p  = $countones(wr_sparsemap_i);
                    m_map[ch][dc] = wr_sparsemap_i;
                    m_dat[ch][dc] = wr_nonzero_data_i;
                    if (m_open && ch == m_oc && dc == m_beats) begin
                        m_beats++;
                        m_onz += p;
                    end else begin
                        if (m_open) m_close(m_oc, m_beats, m_onz);
                        if (dc != 0) m_err = 1;
                        m_ready[ch] = 1'b0;
                        m_oc = ch; m_beats = dc + 1; m_onz = p; m_open = 1;
                    end
                    if (m_beats == 9) begin
                        m_close(m_oc, m_beats, m_onz);
                        m_open = 0;
                    end
                end
            end else if (m_open) begin
                m_close(m_oc, m_beats, m_onz);
                m_open = 0;
            end
        end
    end

    logic [79:0]  exp_w;
    logic [143:0] exp_nz;

    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int c = 0; c < 16; c++) begin
                exp_w[c*5 +: 5]  = 5'(m_words[c]);
                exp_nz[c*9 +: 9] = 9'(m_nz[c]);
            end
            check("m_rd_valid", rd_valid_o, e_rv);
            check("m_rd_last", rd_last_o, e_last);
            check("m_rd_map", rd_sparsemap_o, e_map);
            check("m_rd_data", rd_nonzero_data_o, e_dat);
            check("m_rd_nz_cnt", rd_nz_cnt_o, 6'($countones(e_map)));
            check("m_ready", chunk_ready_o, m_ready);
            check("m_words", chunk_words_o, exp_w);
            check("m_nz_total", chunk_nz_total_o, exp_nz);
            check("m_err", err_o, m_err);
        end
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic beat(input int ch, input int dc, input logic [31:0] map, input int gen);
        wr_valid_i        = 1'b1;
        wr_chunk_count_i  = 4'(ch);
        wr_dat_count_i    = 4'(dc);
        wr_sparsemap_i    = map;
        wr_nonzero_data_i = mk_data(ch, dc, gen);
        step();
    endtask

    task automatic idle();
        wr_valid_i = 1'b0;
        step();
    endtask

    task automatic rd(input int ch, input int dc);
        rd_en_i        = 1'b1;
        rd_chunk_i     = 4'(ch);
        rd_dat_count_i = 4'(dc);
        step();
        rd_en_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; wr_valid_i = 1'b0; wr_sparsemap_i = '0; wr_nonzero_data_i = '0;
        wr_dat_count_i = '0; wr_chunk_count_i = '0; chunk_clr_i = '0;
        rd_en_i = 1'b0; rd_chunk_i = '0; rd_dat_count_i = '0;
        step(); step();
        chk_en = 1'b1;
        check("rst_ready", chunk_ready_o, 16'h0);
        check("rst_err", err_o, 1'b0);
        check("rst_rd_valid", rd_valid_o, 1'b0);
        rst_i = 1'b1;
        step();

        // Full 9-beat chunk closes on its last beat.
        for (int d = 0; d < 9; d++) beat(3, d, 32'h0000000F, 0);
        check("full_ready3", chunk_ready_o[3], 1'b1);
        check("full_words3", chunk_words_o[3*5 +: 5], 5'd9);
        check("full_nz3", chunk_nz_total_o[3*9 +: 9], 9'd36);
        check("full_err", err_o, 1'b0);
        idle();

        // Short chunk closed by a gap, then read of its last beat.
        for (int d = 0; d < 3; d++) beat(0, d, 32'h00FF00FF, 0);
        idle();
        check("short_ready0", chunk_ready_o[0], 1'b1);
        check("short_words0", chunk_words_o[0 +: 5], 5'd3);
        check("short_nz0", chunk_nz_total_o[0 +: 9], 9'd48);
        rd(0, 2);
        check("rd02_valid", rd_valid_o, 1'b1);
        check("rd02_last", rd_last_o, 1'b1);
        check("rd02_data", rd_nonzero_data_o, mk_data(0, 2, 0));
        check("rd02_nzcnt", rd_nz_cnt_o, 6'd16);
        rd(3, 4);
        check("rd34_last", rd_last_o, 1'b0);

        // Back-to-back chunks without a gap.
        beat(1, 0, 32'h1, 0);
        beat(1, 1, 32'h3, 0);
        beat(2, 0, 32'h7, 0);
        check("b2b_ready1", chunk_ready_o[1], 1'b1);
        check("b2b_words1", chunk_words_o[1*5 +: 5], 5'd2);
        check("b2b_err", err_o, 1'b0);
        beat(2, 1, 32'hF0000000, 0);
        idle();
        check("b2b_words2", chunk_words_o[2*5 +: 5], 5'd2);
        check("b2b_nz2", chunk_nz_total_o[2*9 +: 9], 9'd7);

        // Skipped beat is a sticky error; read past stored beats is empty.
        beat(5, 0, 32'hFFFF, 0);
        beat(5, 2, 32'hFF, 0);
        check("skip_err", err_o, 1'b1);
        idle();
        rd(5, 3);
        check("rd53_valid", rd_valid_o, 1'b0);
        check("rd53_data", rd_nonzero_data_o, 256'h0);

        // Out-of-range beat index is dropped without disturbing the open chunk.
        beat(7, 0, 32'h3, 0);
        beat(7, 12, 32'hFFFFFFFF, 0);
        beat(7, 1, 32'h1, 0);
        idle();
        check("drop_words7", chunk_words_o[7*5 +: 5], 5'd2);
        check("drop_nz7", chunk_nz_total_o[7*9 +: 9], 9'd3);

        // Rewrite of chunk 4 beat 0 while reading it returns the old content.
        beat(4, 0, 32'hA5, 0);
        beat(4, 1, 32'h5A, 0);
        idle();
        rd_en_i = 1'b1; rd_chunk_i = 4'd4; rd_dat_count_i = 4'd0;
        beat(4, 0, 32'hFFFF0000, 1);
        rd_en_i = 1'b0;
        check("rbw_valid", rd_valid_o, 1'b1);
        check("rbw_data", rd_nonzero_data_o, mk_data(4, 0, 0));
        check("rbw_ready4", chunk_ready_o[4], 1'b0);
        idle();

        // Release, and release colliding with a close.
        chunk_clr_i = 16'h0001;
        step();
        chunk_clr_i = '0;
        check("clr_ready0", chunk_ready_o[0], 1'b0);
        check("clr_words0", chunk_words_o[0 +: 5], 5'd0);
        beat(8, 0, 32'h1, 0);
        chunk_clr_i = 16'h0100;
        idle();
        chunk_clr_i = '0;
        check("clrclose_ready8", chunk_ready_o[8], 1'b1);
        check("clrclose_words8", chunk_words_o[8*5 +: 5], 5'd1);

        // Reset mid-chunk discards it and clears the sticky error.
        beat(6, 0, 32'h1, 0);
        beat(6, 1, 32'h1, 0);
        rst_i = 1'b0;
        chunk_clr_i = 16'h0008;
        beat(6, 2, 32'h1, 0);
        check("rst_mid_ready", chunk_ready_o, 16'h0);
        check("rst_mid_err", err_o, 1'b0);
        check("rst_mid_words", chunk_words_o, 80'h0);
        rst_i = 1'b1;
        chunk_clr_i = '0;
        beat(6, 0, 32'h3, 2);
        beat(6, 1, 32'h3, 2);
        idle();
        check("post_rst_ready6", chunk_ready_o[6], 1'b1);
        check("post_rst_words6", chunk_words_o[6*5 +: 5], 5'd2);
        check("post_rst_err", err_o, 1'b0);
        rd(6, 1);
        check("post_rst_rd", rd_nonzero_data_o, mk_data(6, 1, 2));
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
